// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: captures per-entry ACU results, picks one per cycle
// round-robin and queues it in a small FIFO toward the ROB / RS tag-match logic.
package cdb_pkg;
   typedef struct packed {
      logic [4:0]  tag;
      logic [31:0] value;
   } sal_t;
endpackage

module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int size  = 15,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [size-1:0]          in_valid,
   input  sal_t [size-1:0]          in_data,
   output logic [size-1:0]          in_ack,
   output logic                     out_valid,
   output sal_t                     out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(size);

   logic [size-1:0] slotValid_q, slotValid_d;
   sal_t            slot_q [size];
   sal_t            mem_q  [DEPTH];
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [PW-1:0]   rrPtr_q, rrPtr_d;

   logic [PW-1:0]   winner;
   logic [PW-1:0]   sel;
   int              idx;
   logic            anyValid;
   logic            push;
   logic            pop;

   // Acknowledge only into an empty holding slot; slot state is the registered one.
   assign in_ack    = in_valid & ~slotValid_q & {size{~flush & rst}};
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[head_q];
   assign occupancy = count_q;

   // First valid slot scanning upward from rrPtr_q with wrap-around.
   always_comb begin
      winner   = '0;
      sel      = '0;
      idx      = 0;
      anyValid = 1'b0;
      for (int k = 0; k < size; k++) begin
         idx = int'(rrPtr_q) + k;
         if (idx >= size) idx = idx - size;
         sel = PW'(idx);
         if (!anyValid && slotValid_q[sel]) begin
            anyValid = 1'b1;
            winner   = sel;
         end
      end
   end

   assign push = anyValid && (count_q != CW'(DEPTH)) && rst && !flush;
   assign pop  = out_valid && out_ready && rst && !flush;

   always_comb begin
      slotValid_d = slotValid_q | in_ack;
      tail_d      = tail_q;
      head_d      = head_q;
      rrPtr_d     = rrPtr_q;
      count_d     = count_q + CW'(push) - CW'(pop);
      if (push) begin
         slotValid_d[winner] = 1'b0;
         tail_d              = tail_q + AW'(1);
         rrPtr_d             = (winner == PW'(size - 1)) ? '0 : winner + PW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      if (flush) begin
         slotValid_d = '0;
         tail_d      = '0;
         head_d      = '0;
         rrPtr_d     = '0;
         count_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slotValid_q <= '0;
         count_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         rrPtr_q     <= '0;
      end else begin
         slotValid_q <= slotValid_d;
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         rrPtr_q     <= rrPtr_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by the control state above.
   always_ff @(posedge clk) begin
      for (int i = 0; i < size; i++) begin
         if (in_ack[i]) slot_q[i] <= in_data[i];
      end
      if (push) mem_q[tail_q] <= slot_q[winner];
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter, checked each cycle against a queue-based
// model of the slots, round-robin pointer and broadcast FIFO.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int SIZE  = 15;
   localparam int DEPTH = 4;
   localparam int OW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [SIZE-1:0]  in_valid;
   sal_t [SIZE-1:0]  in_data;
   logic [SIZE-1:0]  in_ack;
   logic             out_valid;
   sal_t             out_data;
   logic             out_ready;
   logic [OW-1:0]    occupancy;

   int errors = 0;
   int checks = 0;

   bit              mFull [SIZE];
   sal_t            mSlot [SIZE];
   sal_t            mFifo [$];
   int              mRr = 0;
   logic [SIZE-1:0] mLastAck;
   int              expOcc;
   sal_t            expData;

   cdb_arbiter #(.size(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic sal_t mk(int i);
      sal_t d;
      d.tag   = 5'(i);
      d.value = $urandom;
      return d;
   endfunction

   function automatic logic [SIZE-1:0] modelAck();
      logic [SIZE-1:0] a;
      for (int i = 0; i < SIZE; i++) a[i] = in_valid[i] && !mFull[i] && !flush && rst;
      return a;
   endfunction

   task automatic setReq(int i);
      in_valid[i] = 1'b1;
      in_data[i]  = mk(i);
   endtask

   // One clock edge of the reference behaviour, using the inputs held across the edge.
   task automatic modelEdge();
      logic [SIZE-1:0] a;
      int w;
      a = modelAck();
      mLastAck = a;
      if (!rst || flush) begin
         for (int i = 0; i < SIZE; i++) mFull[i] = 1'b0;
         mFifo.delete();
         mRr = 0;
      end else begin
         w = -1;
         if (mFifo.size() < DEPTH)
            for (int k = 0; k < SIZE; k++)
               if (w < 0 && mFull[(mRr + k) % SIZE]) w = (mRr + k) % SIZE;
         if (mFifo.size() != 0 && out_ready) void'(mFifo.pop_front());
         if (w >= 0) begin
            mFifo.push_back(mSlot[w]);
            mFull[w] = 1'b0;
            mRr = (w + 1) % SIZE;
         end
         for (int i = 0; i < SIZE; i++)
            if (a[i]) begin
               mFull[i] = 1'b1;
               mSlot[i] = in_data[i];
            end
      end
   endtask

   task automatic test_reset();
      for (int c = -2; c < 24; c++) begin
         rst = (c >= 0); flush = 1'b0; out_ready = 1'b1;
         if (c == -2) for (int i = 0; i < SIZE; i++) setReq(i);
         @(negedge clk);
         checks += 2;
         if (in_ack !== modelAck()) begin
            errors++; $display("[TB] FAIL reset_ack c=%0d got %h want %h", c, in_ack, modelAck());
         end
         expOcc = mFifo.size(); expData = (expOcc != 0) ? mFifo[0] : '0;
         if (out_valid !== (expOcc != 0) || occupancy !== OW'(expOcc) || (expOcc != 0 && out_data !== expData)) begin
            errors++; $display("[TB] FAIL reset_out c=%0d got v=%b occ=%0d d=%h want v=%b occ=%0d d=%h",
                               c, out_valid, occupancy, out_data, expOcc != 0, expOcc, expData);
         end
         if (c == -1) begin
            checks++;
            if (in_ack !== '0 || out_valid !== 1'b0 || occupancy !== '0) begin
               errors++; $display("[TB] FAIL reset_hold got ack=%h v=%b occ=%0d want 0 0 0", in_ack, out_valid, occupancy);
            end
         end
         if (c == 0) begin
            checks++;
            if (in_ack !== {SIZE{1'b1}}) begin
               errors++; $display("[TB] FAIL reset_release got ack=%h want all ones", in_ack);
            end
         end
         @(posedge clk); modelEdge(); #1; in_valid &= ~mLastAck;
      end
   endtask

   task automatic test_latency();
      for (int c = -1; c < 6; c++) begin
         rst = (c >= 0); flush = 1'b0; out_ready = 1'b1;
         if (c == -1) in_valid = '0;
         if (c == 0) begin in_valid[3] = 1'b1; in_data[3] = mk(3); end
         @(negedge clk);
         checks += 2;
         if (in_ack !== modelAck()) begin
            errors++; $display("[TB] FAIL latency_ack c=%0d got %h want %h", c, in_ack, modelAck());
         end
         expOcc = mFifo.size(); expData = (expOcc != 0) ? mFifo[0] : '0;
         if (out_valid !== (expOcc != 0) || occupancy !== OW'(expOcc) || (expOcc != 0 && out_data !== expData)) begin
            errors++; $display("[TB] FAIL latency_out c=%0d got v=%b occ=%0d d=%h want v=%b occ=%0d d=%h",
                               c, out_valid, occupancy, out_data, expOcc != 0, expOcc, expData);
         end
         if (c >= 0 && c <= 3) begin
            checks++;
            if ((c == 0 && in_ack !== 15'h0008) || (c == 1 && out_valid !== 1'b0) ||
                (c == 2 && (out_valid !== 1'b1 || out_data.tag !== 5'd3)) ||
                (c == 3 && (out_valid !== 1'b0 || occupancy !== '0))) begin
               errors++; $display("[TB] FAIL latency_fixed c=%0d got ack=%h v=%b tag=%0d occ=%0d",
                                  c, in_ack, out_valid, out_data.tag, occupancy);
            end
         end
         @(posedge clk); modelEdge(); #1; in_valid &= ~mLastAck;
      end
   endtask

   task automatic test_rr_wrap();
      int got[$];
      int expOrder[6] = '{12, 13, 14, 2, 3, 0};
      bit ok;
      for (int c = -1; c < 12; c++) begin
         rst = (c >= 0); flush = 1'b0; out_ready = 1'b1;
         if (c == -1) in_valid = '0;
         if (c == 0) setReq(12);
         if (c == 2) begin setReq(2); setReq(13); setReq(14); end
         if (c == 6) begin setReq(0); setReq(3); end
         @(negedge clk);
         checks += 2;
         if (in_ack !== modelAck()) begin
            errors++; $display("[TB] FAIL rr_ack c=%0d got %h want %h", c, in_ack, modelAck());
         end
         expOcc = mFifo.size(); expData = (expOcc != 0) ? mFifo[0] : '0;
         if (out_valid !== (expOcc != 0) || occupancy !== OW'(expOcc) || (expOcc != 0 && out_data !== expData)) begin
            errors++; $display("[TB] FAIL rr_out c=%0d got v=%b occ=%0d d=%h want v=%b occ=%0d d=%h",
                               c, out_valid, occupancy, out_data, expOcc != 0, expOcc, expData);
         end
         if (rst && out_valid === 1'b1) got.push_back(int'(out_data.tag));
         @(posedge clk); modelEdge(); #1; in_valid &= ~mLastAck;
      end
      checks++;
      ok = (got.size() == 6);
      for (int i = 0; i < 6 && ok; i++) if (got[i] != expOrder[i]) ok = 1'b0;
      if (!ok) begin
         errors++; $display("[TB] FAIL rr_order got %p want %p", got, expOrder);
      end
   endtask

   task automatic test_backpressure();
      int pops = 0, firstPop = -1, lastPop = -1;
      logic [SIZE-1:0] seen = '0;
      for (int c = -1; c < 27; c++) begin
         rst = (c >= 0); flush = 1'b0; out_ready = (c >= 8);
         if (c == -1) in_valid = '0;
         if (c == 0) for (int i = 0; i < SIZE; i++) setReq(i);
         if (c == 6) for (int i = 0; i < SIZE; i++) if (mFull[i]) setReq(i);
         if (c == 7) in_valid = '0;
         @(negedge clk);
         checks += 2;
         if (in_ack !== modelAck()) begin
            errors++; $display("[TB] FAIL bp_ack c=%0d got %h want %h", c, in_ack, modelAck());
         end
         expOcc = mFifo.size(); expData = (expOcc != 0) ? mFifo[0] : '0;
         if (out_valid !== (expOcc != 0) || occupancy !== OW'(expOcc) || (expOcc != 0 && out_data !== expData)) begin
            errors++; $display("[TB] FAIL bp_out c=%0d got v=%b occ=%0d d=%h want v=%b occ=%0d d=%h",
                               c, out_valid, occupancy, out_data, expOcc != 0, expOcc, expData);
         end
         if (c == 6) begin
            checks++;
            if (in_ack !== '0 || occupancy !== OW'(DEPTH) || in_valid == '0) begin
               errors++; $display("[TB] FAIL bp_saturate got ack=%h occ=%0d want ack=0 occ=%0d", in_ack, occupancy, DEPTH);
            end
         end
         if (rst && out_valid === 1'b1 && out_ready) begin
            pops++; seen[out_data.tag] = 1'b1;
            if (firstPop < 0) firstPop = c;
            lastPop = c;
         end
         @(posedge clk); modelEdge(); #1; in_valid &= ~mLastAck;
      end
      checks++;
      if (pops != SIZE || seen !== {SIZE{1'b1}} || lastPop - firstPop != SIZE - 1) begin
         errors++; $display("[TB] FAIL bp_drain got pops=%0d seen=%h span=%0d want %0d all-ones %0d",
                            pops, seen, lastPop - firstPop, SIZE, SIZE - 1);
      end
   endtask

   task automatic test_push_pop();
      for (int c = -1; c < 10; c++) begin
         rst = (c >= 0); flush = 1'b0; out_ready = (c >= 4);
         if (c == -1) in_valid = '0;
         if (c == 0) begin setReq(0); setReq(1); setReq(2); end
         if (c == 3) setReq(5);
         @(negedge clk);
         checks += 2;
         if (in_ack !== modelAck()) begin
            errors++; $display("[TB] FAIL pp_ack c=%0d got %h want %h", c, in_ack, modelAck());
         end
         expOcc = mFifo.size(); expData = (expOcc != 0) ? mFifo[0] : '0;
         if (out_valid !== (expOcc != 0) || occupancy !== OW'(expOcc) || (expOcc != 0 && out_data !== expData)) begin
            errors++; $display("[TB] FAIL pp_out c=%0d got v=%b occ=%0d d=%h want v=%b occ=%0d d=%h",
                               c, out_valid, occupancy, out_data, expOcc != 0, expOcc, expData);
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (occupancy !== OW'(3) || out_data.tag !== 5'(c - 4)) begin
               errors++; $display("[TB] FAIL pp_steady c=%0d got occ=%0d tag=%0d want 3 %0d", c, occupancy, out_data.tag, c - 4);
            end
         end
         @(posedge clk); modelEdge(); #1; in_valid &= ~mLastAck;
      end
   endtask

   task automatic test_flush();
      for (int c = -1; c < 12; c++) begin
         rst = (c >= 0); flush = (c == 6); out_ready = (c >= 7);
         if (c == -1) in_valid = '0;
         if (c == 0) for (int i = 0; i < 9; i++) setReq(i);
         if (c == 6) setReq(0);
         @(negedge clk);
         checks += 2;
         if (in_ack !== modelAck()) begin
            errors++; $display("[TB] FAIL flush_ack c=%0d got %h want %h", c, in_ack, modelAck());
         end
         expOcc = mFifo.size(); expData = (expOcc != 0) ? mFifo[0] : '0;
         if (out_valid !== (expOcc != 0) || occupancy !== OW'(expOcc) || (expOcc != 0 && out_data !== expData)) begin
            errors++; $display("[TB] FAIL flush_out c=%0d got v=%b occ=%0d d=%h want v=%b occ=%0d d=%h",
                               c, out_valid, occupancy, out_data, expOcc != 0, expOcc, expData);
         end
         if (c >= 6 && c <= 9) begin
            checks++;
            if ((c == 6 && (in_ack !== '0 || occupancy !== OW'(DEPTH))) ||
                (c == 7 && (out_valid !== 1'b0 || occupancy !== '0 || in_ack !== 15'h0001)) ||
                (c == 8 && out_valid !== 1'b0) ||
                (c == 9 && (out_valid !== 1'b1 || out_data.tag !== 5'd0))) begin
               errors++; $display("[TB] FAIL flush_fixed c=%0d got ack=%h v=%b occ=%0d tag=%0d",
                                  c, in_ack, out_valid, occupancy, out_data.tag);
            end
         end
         @(posedge clk); modelEdge(); #1; in_valid &= ~mLastAck;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 99) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < SIZE; i++)
            if (!in_valid[i] && $urandom_range(0, 3) == 0) setReq(i);
         @(negedge clk);
         checks += 2;
         if (in_ack !== modelAck()) begin
            errors++; $display("[TB] FAIL rand_ack c=%0d got %h want %h", c, in_ack, modelAck());
         end
         expOcc = mFifo.size(); expData = (expOcc != 0) ? mFifo[0] : '0;
         if (out_valid !== (expOcc != 0) || occupancy !== OW'(expOcc) || (expOcc != 0 && out_data !== expData)) begin
            errors++; $display("[TB] FAIL rand_out c=%0d got v=%b occ=%0d d=%h want v=%b occ=%0d d=%h",
                               c, out_valid, occupancy, out_data, expOcc != 0, expOcc, expData);
         end
         @(posedge clk); modelEdge(); #1; in_valid &= ~mLastAck;
      end
   endtask

   // Power-up reset settles the DUT before the model-checked scenarios start.
   initial begin
      rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_data = '0;
      for (int i = 0; i < SIZE; i++) mFull[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_latency();
      test_rr_wrap();
      test_backpressure();
      test_push_pop();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
